// File: rtl/mem_arbiter_pkg.sv
// Types shared by the memory arbiter and its tag-ownership table.
package mem_arbiter_pkg;

    typedef enum logic {OWN_IC = 1'b0, OWN_DC = 1'b1} mem_owner_t;

    typedef struct packed {
        logic       valid;
        mem_owner_t owner;
        logic       drop;
    } mem_tag_entry_t;

    localparam int STARVE_MAX_DEF = 4;

    // Tag 0 is reserved as "no tag", so the tag field must also hold NUM_TAGS itself.
    function automatic int tag_width(input int num_tags);
        return $clog2(num_tags + 1);
    endfunction

endpackage

// File: rtl/sys_defs_pkg.sv
// System-wide bus definitions shared by the cache and memory blocks.
package sys_defs_pkg;

    localparam int NUM_MEM_TAGS = 15;
    localparam int DATA_SIZE    = 64;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the icache, dcache and memory-side signals around the arbiter.
interface mem_arbiter_if
    import sys_defs_pkg::*;
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = NUM_MEM_TAGS,
    parameter int DATA_W   = DATA_SIZE
);
    localparam int TAG_W = tag_width(NUM_TAGS);

    BUS_COMMAND        ic_command;
    logic [31:0]       ic_addr;
    logic [TAG_W-1:0]  ic_response;
    logic [DATA_W-1:0] ic_data;
    logic [TAG_W-1:0]  ic_tag;

    BUS_COMMAND        dc_command;
    logic [31:0]       dc_addr;
    logic [DATA_W-1:0] dc_data;
    logic [TAG_W-1:0]  dc_response;
    logic [DATA_W-1:0] dc_data_o;
    logic [TAG_W-1:0]  dc_tag;

    logic              rollback;

    BUS_COMMAND        proc2mem_command;
    logic [31:0]       proc2mem_addr;
    logic [DATA_W-1:0] proc2mem_data;
    logic [TAG_W-1:0]  mem2proc_response;
    logic [DATA_W-1:0] mem2proc_data;
    logic [TAG_W-1:0]  mem2proc_tag;

    logic [TAG_W:0]    outstanding_cnt;
    logic              err_bad_tag;

    modport slave (
        input  ic_command, ic_addr, dc_command, dc_addr, dc_data, rollback,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        output ic_response, ic_data, ic_tag, dc_response, dc_data_o, dc_tag,
               proc2mem_command, proc2mem_addr, proc2mem_data,
               outstanding_cnt, err_bad_tag
    );

    modport master (
        output ic_command, ic_addr, dc_command, dc_addr, dc_data, rollback,
               mem2proc_response, mem2proc_data, mem2proc_tag,
        input  ic_response, ic_data, ic_tag, dc_response, dc_data_o, dc_tag,
               proc2mem_command, proc2mem_addr, proc2mem_data,
               outstanding_cnt, err_bad_tag
    );

endinterface

// File: rtl/mem_arbiter_tag_table.sv
// Per-tag ownership table: allocation on accepted loads, clear on return,
// drop marking of dcache entries on rollback, and a live-entry count.
module mem_tag_table
    import mem_arbiter_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_en_i,
    input  logic [TAG_W-1:0] alloc_tag_i,
    input  mem_owner_t       alloc_owner_i,
    input  logic [TAG_W-1:0] clr_tag_i,
    input  logic             drop_dc_i,
    output mem_tag_entry_t   lkp_entry_o,
    output logic [TAG_W:0]   count_o
);
    localparam int DEPTH = 2 ** TAG_W;

    mem_tag_entry_t [DEPTH-1:0] entry_q, entry_d;

    // Later updates override earlier ones: a same-cycle re-allocation beats the clear.
    always_comb begin
        entry_d = entry_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (drop_dc_i && entry_q[i].valid && entry_q[i].owner == OWN_DC)
                entry_d[i].drop = 1'b1;
        end
        if (entry_q[clr_tag_i].valid)
            entry_d[clr_tag_i] = '0;
        if (alloc_en_i)
            entry_d[alloc_tag_i] = '{valid: 1'b1, owner: alloc_owner_i, drop: 1'b0};
    end

    always_comb begin
        lkp_entry_o = entry_q[clr_tag_i];
        count_o     = '0;
        for (int i = 0; i < DEPTH; i++)
            count_o = count_o + (TAG_W+1)'(entry_q[i].valid);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) entry_q <= '0;
        else       entry_q <= entry_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory bus between icache and dcache: same-cycle grant with dcache
// priority and an icache starvation guard, and routes load returns by tag owner.
module mem_arbiter
    import sys_defs_pkg::*;
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS   = NUM_MEM_TAGS,
    parameter int DATA_W     = DATA_SIZE,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int TAG_W = tag_width(NUM_TAGS);
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    logic              ic_req, dc_req, ic_win, dc_win;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic              err_q, err_d;
    logic              alloc_en;
    mem_owner_t        alloc_owner;
    mem_tag_entry_t    ret_entry;
    logic              ret_live;
    logic [DATA_W-1:0] ret_data;

    // A rolled-back dcache request never reaches memory, so it cannot block icache.
    always_comb begin
        ic_req = (bus.ic_command != BUS_NONE);
        dc_req = (bus.dc_command != BUS_NONE) && !bus.rollback;
        ic_win = ic_req && (!dc_req || starve_q == SC_W'(STARVE_MAX));
        dc_win = dc_req && !ic_win;

        bus.proc2mem_command = BUS_NONE;
        bus.proc2mem_addr    = '0;
        bus.proc2mem_data    = '0;
        bus.ic_response      = '0;
        bus.dc_response      = '0;
        if (ic_win) begin
            bus.proc2mem_command = bus.ic_command;
            bus.proc2mem_addr    = bus.ic_addr;
            bus.ic_response      = bus.mem2proc_response;
        end else if (dc_win) begin
            bus.proc2mem_command = bus.dc_command;
            bus.proc2mem_addr    = bus.dc_addr;
            bus.proc2mem_data    = bus.dc_data;
            bus.dc_response      = bus.mem2proc_response;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!ic_req || ic_win)
            starve_d = '0;
        else if (starve_q != SC_W'(STARVE_MAX))
            starve_d = starve_q + SC_W'(1);
    end

    assign alloc_en    = (bus.mem2proc_response != '0) && (bus.proc2mem_command == BUS_LOAD);
    assign alloc_owner = ic_win ? OWN_IC : OWN_DC;

    mem_tag_table #(.TAG_W(TAG_W)) u_tag_table (
        .clock         (clock),
        .reset         (reset),
        .alloc_en_i    (alloc_en),
        .alloc_tag_i   (bus.mem2proc_response),
        .alloc_owner_i (alloc_owner),
        .clr_tag_i     (bus.mem2proc_tag),
        .drop_dc_i     (bus.rollback),
        .lkp_entry_o   (ret_entry),
        .count_o       (bus.outstanding_cnt)
    );

    // A dcache return in the rollback cycle is squashed even before drop is recorded.
    always_comb begin
        ret_live    = (bus.mem2proc_tag != '0) && ret_entry.valid && !ret_entry.drop;
        ret_data    = bus.mem2proc_data;
        bus.ic_data   = ret_data;
        bus.dc_data_o = ret_data;
        bus.ic_tag  = (ret_live && ret_entry.owner == OWN_IC) ? bus.mem2proc_tag : '0;
        bus.dc_tag  = (ret_live && ret_entry.owner == OWN_DC && !bus.rollback) ? bus.mem2proc_tag : '0;
        err_d       = err_q | ((bus.mem2proc_tag != '0) && !ret_entry.valid);
        bus.err_bad_tag = err_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

endmodule
